scalar_add_regs: RTL and testbench
==================================

# scalar_add_regs

Register-file responder and sequencer for the scalar-add accelerator. It executes host commands (ident, register write, register read, launch) arriving over a valid/ready command channel, and returns exactly one response per command over a valid/ready response channel. It sits between the Verilator host command port and the adder datapath, and owns the operand registers a and b, the result register y, and the launch counter.

## Interface
Parameters:
- ADD_CYCLES, 4: cycles spent in the ADD state per launch; legal range 1..255.
- IDENT, 32'hdeadbeef: value returned by the ident command.

Ports:
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  responder can accept a command.
- cmd_opcode  in  32  command code: 0 ident, 1 write, 2 read, 3 launch.
- cmd_id  in  32  register select: 0 a, 1 b, 2 y, 3 count (read-only).
- cmd_addr  in  32  word index within the register; only 0 is legal.
- cmd_data  in  32  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  host accepts the response.
- rsp_data  out  32  response payload.
- rsp_err  out  1  command was illegal; no state was changed.
- busy  out  1  high in the ADD state.

## Operation
- FSM states: IDLE, ADD, RESP. cmd_ready = (state == IDLE). A command is accepted when cmd_valid and cmd_ready are both high at a rising edge.
- IDLE, accepting ident: rsp_data <= IDENT, rsp_err <= 0, next state RESP.
- IDLE, accepting write (id 0..2, addr 0): the selected register <= cmd_data on the accept edge. rsp_data <= 0, next state RESP.
- IDLE, accepting read (id 0..3, addr 0): rsp_data <= the register value sampled on the accept edge, next state RESP.
- IDLE, accepting launch: load the cycle counter with ADD_CYCLES-1, next state ADD. In ADD, the counter decrements each cycle.
- When the counter reaches 0 in ADD:
  - y <= (a + b) mod 2^32; the carry is discarded.
  - count <= count + 1, wrapping from 0xffffffff to 0.
  - rsp_data <= the new y value; next state RESP.
- Illegal command: unknown opcode, write to id 3 or any id > 3, read of id > 3, or addr != 0 on a write or read.
  - Response is rsp_err = 1 with rsp_data = 0; registers are unchanged.
  - cmd_addr and cmd_id are ignored for ident and launch.
- RESP: rsp_valid = 1 and rsp_data/rsp_err are held stable. When rsp_ready is high, go to IDLE.
- a and b are only written by host commands. Operand values are sampled at the final ADD edge; no host write can occur during ADD because cmd_ready is 0.

## Timing
- Reset (asynchronous assert, any state, including mid-ADD or mid-RESP):
  - state = IDLE.
  - a, b, y, count, rsp_data = 0; rsp_err = 0.
  - rsp_valid = 0, busy = 0.
  - cmd_ready = 1 while reset is deasserted and the state is IDLE; an interrupted launch produces no response.
- Reset deassertion is synchronised by the integrator; the block must accept a command on the first edge after release.
- Latency for ident, write, read, and illegal commands: the command is accepted at edge N and rsp_valid is high from edge N+1.
- Latency for launch: accepted at edge N; busy is high during cycles N+1..N+ADD_CYCLES; rsp_valid is high from edge N+ADD_CYCLES+1.
- With rsp_ready held high, the next command is accepted at the edge following the response handshake. Sustained throughput is 1 command per 2 cycles (non-launch).
- The response is held indefinitely while rsp_ready is low. rsp_ready is ignored outside RESP.
- cmd_valid during ADD or RESP is not accepted; the host must keep the command stable until accepted.
- Outputs are registered, except cmd_ready, rsp_valid, and busy, which are decoded from the state register.

## Test plan
- Ident after reset: cmd_valid with opcode 0 at the first edge -> rsp_valid one cycle later, rsp_data = 0xdeadbeef, rsp_err = 0.
- Write then launch then read-back:
  - write a = 5, write b = 7, launch -> response after ADD_CYCLES+1 cycles with rsp_data = 12, busy high for exactly 4 cycles.
  - read y = 12; read count = 1.
- Overflow wrap: a = 0xffffffff, b = 2, launch -> y = 1, rsp_err = 0.
- Illegal commands, each returning rsp_err = 1 and rsp_data = 0 with registers unchanged:
  - opcode 7.
  - write to id 3.
  - read of id 4.
  - write with addr 1 (a stays at its prior value).
- Backpressure: hold rsp_ready = 0 for 10 cycles after a read of b -> rsp_valid and rsp_data stay stable and cmd_ready stays 0. Release -> IDLE on the next cycle.
- Reset mid-ADD: launch, then assert reset on the 2nd busy cycle -> immediately busy = 0, rsp_valid = 0, a = b = y = count = 0; no stale response after release. An ident then succeeds.

Source files
------------

// File: rtl/scalar_add_regs.sv
// scalar_add_regs: command responder and sequencer for the scalar-add unit.
// Owns operands a/b, result y and the launch counter.
module scalar_add_regs #(
  parameter int          ADD_CYCLES = 4,
  parameter logic [31:0] IDENT      = 32'hdeadbeef
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_opcode,
  input  logic [31:0] cmd_id,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [7:0]  cnt;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] y;
  logic [31:0] count;
  logic [31:0] rd_val;
  logic [31:0] sum;
  logic        accept;
  logic        is_ident;
  logic        is_wr;
  logic        is_rd;
  logic        is_launch;
  logic        addr_ok;

  assign cmd_ready = (state == IDLE) && reset;
  assign rsp_valid = (state == RESP);
  assign busy      = (state == ADD);
  assign accept    = cmd_valid && cmd_ready;
  assign sum       = a + b;

  assign addr_ok   = (cmd_addr == 32'd0);
  assign is_ident  = (cmd_opcode == 32'd0);
  assign is_wr     = (cmd_opcode == 32'd1) && addr_ok
                     && (cmd_id < 32'd3);
  assign is_rd     = (cmd_opcode == 32'd2) && addr_ok
                     && (cmd_id < 32'd4);
  assign is_launch = (cmd_opcode == 32'd3);

  always_comb begin
    rd_val = 32'd0;
    unique case (cmd_id[1:0])
      2'd0:    rd_val = a;
      2'd1:    rd_val = b;
      2'd2:    rd_val = y;
      default: rd_val = count;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept)
              state_nx = is_launch ? ADD : RESP;
      ADD:  if (cnt == 8'd0) state_nx = RESP;
      RESP: if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt      <= 8'd0;
      a        <= 32'd0;
      b        <= 32'd0;
      y        <= 32'd0;
      count    <= 32'd0;
      rsp_data <= 32'd0;
      rsp_err  <= 1'b0;
    end else if (accept) begin
      unique case (1'b1)
        is_ident: begin
          rsp_data <= IDENT;
          rsp_err  <= 1'b0;
        end
        is_wr: begin
          unique case (cmd_id[1:0])
            2'd0:    a <= cmd_data;
            2'd1:    b <= cmd_data;
            default: y <= cmd_data;
          endcase
          rsp_data <= 32'd0;
          rsp_err  <= 1'b0;
        end
        is_rd: begin
          rsp_data <= rd_val;
          rsp_err  <= 1'b0;
        end
        is_launch: begin
          cnt <= 8'(ADD_CYCLES - 1);
        end
        default: begin
          rsp_data <= 32'd0;
          rsp_err  <= 1'b1;
        end
      endcase
    end else if (state == ADD) begin
      // operands are sampled only on the final ADD edge
      if (cnt == 8'd0) begin
        y        <= sum;
        count    <= count + 32'd1;
        rsp_data <= sum;
        rsp_err  <= 1'b0;
      end else begin
        cnt <= cnt - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_scalar_add_regs.sv
// tb_scalar_add_regs: directed self-checking bench for scalar_add_regs.
// Expected values are hand-computed constants.
module tb_scalar_add_regs;

  logic        clock;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_opcode;
  logic [31:0] cmd_id;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  scalar_add_regs dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_opcode (cmd_opcode),
    .cmd_id     (cmd_id),
    .cmd_addr   (cmd_addr),
    .cmd_data   (cmd_data),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] op,
                       input logic [31:0] id,
                       input logic [31:0] addr,
                       input logic [31:0] data);
    cmd_opcode = op;
    cmd_id     = id;
    cmd_addr   = addr;
    cmd_data   = data;
    cmd_valid  = 1'b1;
    @(posedge clock);
    #1;
    cmd_valid  = 1'b0;
  endtask

  task automatic rsp(input string tag,
                     input logic [31:0] data,
                     input logic err);
    chk({tag, ".valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, ".data"}, rsp_data, data);
    chk({tag, ".err"}, 32'(rsp_err), 32'(err));
    @(posedge clock);
    #1;
  endtask

  task automatic launch(input string tag, input logic [31:0] exp);
    int nb;
    nb = 0;
    issue(32'd3, 32'd0, 32'd0, 32'd0);
    for (int i = 0; i < 20 && !rsp_valid; i++) begin
      if (busy) nb++;
      @(posedge clock);
      #1;
    end
    chk({tag, ".busy_cycles"}, 32'(nb), 32'd4);
    rsp(tag, exp, 1'b0);
  endtask

  initial begin
    reset      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_opcode = 32'd0;
    cmd_id     = 32'd0;
    cmd_addr   = 32'd0;
    cmd_data   = 32'd0;
    rsp_ready  = 1'b1;

    #3;
    chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.rsp_data", rsp_data, 32'd0);
    chk("rst.rsp_err", 32'(rsp_err), 32'd0);

    #9;
    reset = 1'b1;
    #1;
    chk("rel.cmd_ready", 32'(cmd_ready), 32'd1);

    issue(32'd0, 32'd0, 32'd0, 32'd0);
    chk("ident.cmd_ready", 32'(cmd_ready), 32'd0);
    rsp("ident", 32'hdeadbeef, 1'b0);

    issue(32'd1, 32'd0, 32'd0, 32'd5);
    rsp("wr_a", 32'd0, 1'b0);
    issue(32'd1, 32'd1, 32'd0, 32'd7);
    rsp("wr_b", 32'd0, 1'b0);
    launch("add", 32'd12);
    issue(32'd2, 32'd2, 32'd0, 32'd0);
    rsp("rd_y", 32'd12, 1'b0);
    issue(32'd2, 32'd3, 32'd0, 32'd0);
    rsp("rd_cnt1", 32'd1, 1'b0);

    issue(32'd1, 32'd0, 32'd0, 32'hffffffff);
    rsp("wr_a2", 32'd0, 1'b0);
    issue(32'd1, 32'd1, 32'd0, 32'd2);
    rsp("wr_b2", 32'd0, 1'b0);
    launch("ovf", 32'd1);
    issue(32'd2, 32'd3, 32'd0, 32'd0);
    rsp("rd_cnt2", 32'd2, 1'b0);

    issue(32'd7, 32'd0, 32'd0, 32'd0);
    rsp("bad_op", 32'd0, 1'b1);
    issue(32'd1, 32'd3, 32'd0, 32'd55);
    rsp("wr_id3", 32'd0, 1'b1);
    issue(32'd2, 32'd3, 32'd0, 32'd0);
    rsp("rd_cnt3", 32'd2, 1'b0);
    issue(32'd2, 32'd4, 32'd0, 32'd0);
    rsp("rd_id4", 32'd0, 1'b1);
    issue(32'd1, 32'd0, 32'd1, 32'd9);
    rsp("wr_addr1", 32'd0, 1'b1);
    issue(32'd2, 32'd0, 32'd0, 32'd0);
    rsp("rd_a_kept", 32'hffffffff, 1'b0);

    rsp_ready = 1'b0;
    issue(32'd2, 32'd1, 32'd0, 32'd0);
    for (int i = 0; i < 10; i++) begin
      chk("bp.valid", 32'(rsp_valid), 32'd1);
      chk("bp.data", rsp_data, 32'd2);
      chk("bp.cmd_ready", 32'(cmd_ready), 32'd0);
      @(posedge clock);
      #1;
    end
    rsp_ready = 1'b1;
    @(posedge clock);
    #1;
    chk("bp.idle_ready", 32'(cmd_ready), 32'd1);
    chk("bp.idle_valid", 32'(rsp_valid), 32'd0);

    issue(32'd3, 32'd0, 32'd0, 32'd0);
    @(posedge clock);
    #1;
    chk("mid.busy_before", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid.busy", 32'(busy), 32'd0);
    chk("mid.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid.rsp_data", rsp_data, 32'd0);
    @(posedge clock);
    #2;
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock);
      #1;
      chk("post.rsp_valid", 32'(rsp_valid), 32'd0);
      chk("post.busy", 32'(busy), 32'd0);
    end
    issue(32'd2, 32'd0, 32'd0, 32'd0);
    rsp("post.a", 32'd0, 1'b0);
    issue(32'd2, 32'd1, 32'd0, 32'd0);
    rsp("post.b", 32'd0, 1'b0);
    issue(32'd2, 32'd2, 32'd0, 32'd0);
    rsp("post.y", 32'd0, 1'b0);
    issue(32'd2, 32'd3, 32'd0, 32'd0);
    rsp("post.cnt", 32'd0, 1'b0);
    issue(32'd0, 32'd9, 32'd9, 32'd0);
    rsp("post.ident", 32'hdeadbeef, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
